// File: rtl/nn_polar_ss_generator.sv
// Polar (sign-magnitude) binary-to-stochastic encoder.
// Latches a magnitude and sign, then emits a unipolar bitstream whose density is
// MAG/(2^N-1), using a maximal-length Fibonacci LFSR compared against the magnitude.
// The stream either runs for a programmed number of bits or continuously (length 0).
module nn_polar_ss_generator #(
  parameter int unsigned N    = 8,
  parameter int unsigned L    = 16,
  parameter int unsigned SEED = 1
) (
  input  logic         CLK,
  input  logic         INIT,
  input  logic         EN,
  input  logic         LOAD,
  input  logic [N-1:0] MAG_IN,
  input  logic         SIGN_IN,
  input  logic [L-1:0] LEN_IN,
  output logic         SS,
  output logic         SIGN_out,
  output logic         SS_VALID,
  output logic         BUSY,
  output logic         DONE,
  output logic [L-1:0] ONES_CNT
);

  // Feedback tap mask: bit (t-1) set for each tap t of the maximal-length polynomial.
  function automatic logic [15:0] tap_mask(input int unsigned n);
    case (n)
      4:       tap_mask = 16'h000C;
      5:       tap_mask = 16'h0014;
      6:       tap_mask = 16'h0030;
      7:       tap_mask = 16'h0060;
      8:       tap_mask = 16'h00B8;
      9:       tap_mask = 16'h0110;
      10:      tap_mask = 16'h0240;
      11:      tap_mask = 16'h0500;
      12:      tap_mask = 16'h0E08;
      13:      tap_mask = 16'h1C80;
      14:      tap_mask = 16'h3802;
      15:      tap_mask = 16'h6000;
      16:      tap_mask = 16'hD008;
      default: tap_mask = 16'h0000;
    endcase
  endfunction

  localparam logic [15:0]  TapMaskFull = tap_mask(N);
  localparam logic [N-1:0] TapMask     = TapMaskFull[N-1:0];
  localparam logic [N-1:0] SeedRaw     = SEED[N-1:0];
  // An all-zero LFSR would lock up, so a zero seed is promoted to 1.
  localparam logic [N-1:0] SeedEff     = (SeedRaw == '0) ? N'(1) : SeedRaw;

  typedef enum logic {StIdle, StRun} state_e;

  state_e       state_q, state_d;
  logic [N-1:0] lfsr_q, lfsr_d;
  logic [N-1:0] mag_q, mag_d;
  logic [L-1:0] len_q, len_d;
  logic [L-1:0] bit_cnt_q, bit_cnt_d;
  logic [L-1:0] ones_q, ones_d;
  logic         ss_q, ss_d;
  logic         sign_q, sign_d;
  logic         valid_q, valid_d;
  logic         done_q, done_d;

  logic [N-1:0] lfsr_next;
  logic         sample;
  logic         last_done;

  assign lfsr_next = {lfsr_q[N-2:0], ^(lfsr_q & TapMask)};
  assign sample    = (lfsr_q <= mag_q);
  // bit_cnt reaches len_reg one cycle after the final bit went out; that cycle closes the stream.
  assign last_done = (len_q != '0) && (bit_cnt_q == len_q);

  // State register with asynchronous active-low reset.
  always_ff @(posedge CLK or negedge INIT) begin
    if (!INIT) begin
      state_q   <= StIdle;
      lfsr_q    <= SeedEff;
      mag_q     <= '0;
      len_q     <= '0;
      bit_cnt_q <= '0;
      ones_q    <= '0;
      ss_q      <= 1'b0;
      sign_q    <= 1'b0;
      valid_q   <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      lfsr_q    <= lfsr_d;
      mag_q     <= mag_d;
      len_q     <= len_d;
      bit_cnt_q <= bit_cnt_d;
      ones_q    <= ones_d;
      ss_q      <= ss_d;
      sign_q    <= sign_d;
      valid_q   <= valid_d;
      done_q    <= done_d;
    end
  end

  // Next-state: LOAD beats EN, EN=0 freezes progress, otherwise RUN emits or closes.
  always_comb begin
    state_d   = state_q;
    lfsr_d    = lfsr_q;
    mag_d     = mag_q;
    len_d     = len_q;
    bit_cnt_d = bit_cnt_q;
    ones_d    = ones_q;
    sign_d    = sign_q;
    ss_d      = 1'b0;
    valid_d   = 1'b0;
    done_d    = 1'b0;
    if (LOAD) begin
      mag_d     = MAG_IN;
      sign_d    = SIGN_IN;
      len_d     = LEN_IN;
      bit_cnt_d = '0;
      ones_d    = '0;
      state_d   = StRun;
    end else if (EN) begin
      unique case (state_q)
        StRun: begin
          if (last_done) begin
            state_d = StIdle;
            done_d  = 1'b1;
          end else begin
            ss_d      = sample;
            valid_d   = 1'b1;
            lfsr_d    = lfsr_next;
            bit_cnt_d = bit_cnt_q + L'(1);
            if (sample && (ones_q != '1)) begin
              ones_d = ones_q + L'(1);
            end
          end
        end
        StIdle: ;
      endcase
    end
  end

  // Registered outputs, plus BUSY as a pure state decode.
  always_comb begin
    SS       = ss_q;
    SIGN_out = sign_q;
    SS_VALID = valid_q;
    DONE     = done_q;
    ONES_CNT = ones_q;
    BUSY     = (state_q == StRun);
  end

endmodule

// File: tb/tb_nn_polar_ss_generator.sv
// Self-checking bench for nn_polar_ss_generator (N=8, L=16).
// Expected SS bits come from an independent LFSR model and are queued as stimulus is
// driven; a negedge monitor pops one entry for every SS_VALID sample the DUT produces.
module tb_nn_polar_ss_generator;

  logic        CLK = 1'b0;
  logic        INIT = 1'b0;
  logic        EN = 1'b0;
  logic        LOAD = 1'b0;
  logic [7:0]  MAG_IN = '0;
  logic        SIGN_IN = 1'b0;
  logic [15:0] LEN_IN = '0;
  logic        SS;
  logic        SIGN_out;
  logic        SS_VALID;
  logic        BUSY;
  logic        DONE;
  logic [15:0] ONES_CNT;

  nn_polar_ss_generator #(
    .N    (8),
    .L    (16),
    .SEED (1)
  ) dut (
    .CLK      (CLK),
    .INIT     (INIT),
    .EN       (EN),
    .LOAD     (LOAD),
    .MAG_IN   (MAG_IN),
    .SIGN_IN  (SIGN_IN),
    .LEN_IN   (LEN_IN),
    .SS       (SS),
    .SIGN_out (SIGN_out),
    .SS_VALID (SS_VALID),
    .BUSY     (BUSY),
    .DONE     (DONE),
    .ONES_CNT (ONES_CNT)
  );

  always #5 CLK = ~CLK;

  int         n_vec = 0;
  int         n_err = 0;
  int         done_cnt = 0;
  int         done_exp = 0;
  int         ones_m = 0;
  logic [7:0] m_lfsr = 8'd1;
  logic [7:0] mag_cur = '0;
  bit         exp_q[$];
  bit         exp_bit;

  task automatic check_eq(input string tag, input longint got, input longint exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Model of the x^8+x^6+x^5+x^4+1 Fibonacci LFSR, shifting left.
  function automatic logic [7:0] m_step(input logic [7:0] s);
    return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
  endfunction

  // Scoreboard consumer and DONE pulse counter.
  always @(negedge CLK) begin
    if (INIT) begin
      if (DONE) done_cnt++;
      if (SS_VALID) begin
        if (exp_q.size() == 0) begin
          check_eq("sb_underflow", 1, 0);
        end else begin
          exp_bit = exp_q.pop_front();
          check_eq("ss_bit", SS, exp_bit);
        end
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_load(input logic [7:0] mag, input logic sign, input logic [15:0] len);
    MAG_IN  = mag;
    SIGN_IN = sign;
    LEN_IN  = len;
    LOAD    = 1'b1;
    tick();
    LOAD    = 1'b0;
    mag_cur = mag;
    ones_m  = 0;
    check_eq("load_busy", BUSY, 1);
    check_eq("load_valid", SS_VALID, 0);
    check_eq("load_ones", ONES_CNT, 0);
    check_eq("load_sign", SIGN_out, sign);
  endtask

  task automatic emit(input int n);
    bit b;
    for (int i = 0; i < n; i++) begin
      EN = 1'b1;
      b  = (m_lfsr <= mag_cur);
      exp_q.push_back(b);
      if (b && ones_m < 65535) ones_m++;
      m_lfsr = m_step(m_lfsr);
      tick();
    end
  endtask

  task automatic finish_check();
    EN = 1'b1;
    tick();
    check_eq("done_pulse", DONE, 1);
    check_eq("done_busy", BUSY, 0);
    check_eq("done_valid", SS_VALID, 0);
    check_eq("done_ones", ONES_CNT, ones_m);
    done_exp++;
    tick();
    check_eq("done_clear", DONE, 0);
    check_eq("done_count", done_cnt, done_exp);
  endtask

  task automatic run_stream(input logic [7:0] mag, input logic sign, input logic [15:0] len);
    do_load(mag, sign, len);
    emit(int'(len));
    finish_check();
  endtask

  initial begin
    bit en_t;
    int got_v;
    // Power-on reset
    #12;
    check_eq("rst_ss", SS, 0);
    check_eq("rst_sign", SIGN_out, 0);
    check_eq("rst_valid", SS_VALID, 0);
    check_eq("rst_busy", BUSY, 0);
    check_eq("rst_done", DONE, 0);
    check_eq("rst_ones", ONES_CNT, 0);
    #11 INIT = 1'b1;
    m_lfsr = 8'd1;

    // mag=0: all zeros, negative sign
    run_stream(8'd0, 1'b1, 16'd255);
    check_eq("mag0_ones", ONES_CNT, 0);
    check_eq("mag0_sign", SIGN_out, 1);

    // mag=100 and full-scale over one LFSR period
    run_stream(8'd100, 1'b0, 16'd255);
    check_eq("mag100_ones", ONES_CNT, 100);
    run_stream(8'd255, 1'b0, 16'd255);
    check_eq("mag255_ones", ONES_CNT, 255);

    // EN toggling: exactly 10 valid bits, zeros on stalled cycles
    do_load(8'd128, 1'b0, 16'd10);
    en_t  = 1'b1;
    got_v = 0;
    while (got_v < 10) begin
      EN = en_t;
      if (en_t) begin
        exp_q.push_back(m_lfsr <= mag_cur);
        if (m_lfsr <= mag_cur) ones_m++;
        m_lfsr = m_step(m_lfsr);
        got_v++;
      end
      tick();
      if (!en_t) begin
        check_eq("en0_ss", SS, 0);
        check_eq("en0_valid", SS_VALID, 0);
      end
      en_t = !en_t;
    end
    EN = 1'b0;
    tick();
    check_eq("en0_no_done", DONE, 0);
    check_eq("en0_busy", BUSY, 1);
    finish_check();

    // Mid-stream reload aborts the old stream without a DONE
    do_load(8'd50, 1'b0, 16'd255);
    emit(20);
    check_eq("abort_no_done", done_cnt, done_exp);
    run_stream(8'd255, 1'b1, 16'd4);
    check_eq("reload_ones", ONES_CNT, 4);
    check_eq("reload_sign", SIGN_out, 1);

    // Continuous mode: never finishes, ONES_CNT saturates
    do_load(8'd255, 1'b0, 16'd0);
    emit(70000);
    check_eq("cont_no_done", done_cnt, done_exp);
    check_eq("cont_busy", BUSY, 1);
    check_eq("cont_ones_sat", ONES_CNT, 65535);
    check_eq("cont_valid", SS_VALID, 1);

    // Asynchronous reset mid-stream, away from the clock edge
    #6 INIT = 1'b0;
    #1;
    check_eq("arst_ss", SS, 0);
    check_eq("arst_sign", SIGN_out, 0);
    check_eq("arst_valid", SS_VALID, 0);
    check_eq("arst_busy", BUSY, 0);
    check_eq("arst_done", DONE, 0);
    check_eq("arst_ones", ONES_CNT, 0);
    #20 INIT = 1'b1;
    m_lfsr = 8'd1;

    // LFSR restarts from SEED: same streams as after power-on
    run_stream(8'd0, 1'b1, 16'd255);
    run_stream(8'd100, 1'b0, 16'd255);
    check_eq("rerun_ones", ONES_CNT, 100);

    repeat (3) tick();
    check_eq("sb_empty", exp_q.size(), 0);
    check_eq("final_done_count", done_cnt, done_exp);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
